// File: rtl/hand_datapath.sv
`default_nettype none
// ============================================================================
// Module      : hand_datapath
// Description : Six-slot card store for one baccarat hand with player/dealer
//               score derivation and sticky rejected-load flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hand_datapath (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] new_card,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] cards_dealt,
    output logic       load_error
);

    localparam logic [3:0] c_MIN_RANK = 4'd1;
    localparam logic [3:0] c_MAX_RANK = 4'd13;

    // Slot order: 0..2 player cards 1..3, 3..5 dealer cards 1..3
    logic [5:0][3:0] r_slots;
    logic [2:0]      r_cards_dealt;
    logic            r_load_error;

    logic [5:0] w_strobes;
    logic       w_any_strobe;
    logic       w_one_hot;
    logic       w_card_ok;
    logic       w_target_empty;
    logic       w_accept;
    logic       w_reject;

    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank <= 4'd9) ? rank : 4'd0;
    endfunction

    function automatic logic [3:0] hand_score(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] sum;
        sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
        if (sum >= 5'd20)
            sum = sum - 5'd20;
        else if (sum >= 5'd10)
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

    assign w_strobes    = {load_dcard3, load_dcard2, load_dcard1,
                           load_pcard3, load_pcard2, load_pcard1};
    assign w_any_strobe = |w_strobes;
    assign w_one_hot    = w_any_strobe && ((w_strobes & (w_strobes - 6'd1)) == 6'd0);
    assign w_card_ok    = (new_card >= c_MIN_RANK) && (new_card <= c_MAX_RANK);

    always_comb begin
        w_target_empty = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (w_strobes[i] && (r_slots[i] == 4'd0))
                w_target_empty = 1'b1;
        end
    end

    assign w_accept = w_one_hot && w_card_ok && w_target_empty;
    assign w_reject = w_any_strobe && !w_accept;

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            r_slots       <= '0;
            r_cards_dealt <= 3'd0;
            r_load_error  <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < 6; i++) begin
                    if (w_strobes[i])
                        r_slots[i] <= new_card;
                end
                r_cards_dealt <= r_cards_dealt + 3'd1;
            end
            if (w_reject)
                r_load_error <= 1'b1;
        end
    end

    assign pcard1      = r_slots[0];
    assign pcard2      = r_slots[1];
    assign pcard3      = r_slots[2];
    assign dcard1      = r_slots[3];
    assign dcard2      = r_slots[4];
    assign dcard3      = r_slots[5];
    assign cards_dealt = r_cards_dealt;
    assign load_error  = r_load_error;

    assign pscore = hand_score(r_slots[0], r_slots[1], r_slots[2]);
    assign dscore = hand_score(r_slots[3], r_slots[4], r_slots[5]);

endmodule
`default_nettype wire

// File: doc/hand_datapath.md
# hand_datapath

Card-holding and scoring datapath for one baccarat hand. It captures the dealt card into one of six card slots whenever the game state machine pulses a load strobe, and exposes the cards for the seven-segment displays. It derives the player and dealer baccarat scores that the state machine uses for its third-card and winner decisions. It sits between the card dealer (source of `new_card`) and the game state machine (source of `load_*`, consumer of `pscore`, `dscore` and `pcard3`).

## Interface
Parameters:
- none

Ports:
- `slow_clock` in 1: sole clock; all state updates on its rising edge.
- `resetb` in 1: reset, synchronous, active-low; clock slow_clock.
- `new_card` in 4: card rank offered by the dealer. Legal values are 1..13 (A..K); 0, 14 and 15 are illegal.
- `load_pcard1`, `load_pcard2`, `load_pcard3` in 1 each: capture `new_card` into player slot 1/2/3.
- `load_dcard1`, `load_dcard2`, `load_dcard3` in 1 each: capture `new_card` into dealer slot 1/2/3.
- `pcard1`, `pcard2`, `pcard3` out 4 each: registered player card ranks. 0 means the slot is empty.
- `dcard1`, `dcard2`, `dcard3` out 4 each: registered dealer card ranks. 0 means the slot is empty.
- `pscore` out 4: player hand score, 0..9.
- `dscore` out 4: dealer hand score, 0..9.
- `cards_dealt` out 3: number of slots filled in the current hand, 0..6.
- `load_error` out 1: sticky flag; set by any rejected load.

## Operation
Reset:
- When `resetb` is 0 at a rising edge, all six slots, `cards_dealt` and `load_error` go to 0.
- Reset has priority over every load strobe.
- Because scores are derived from the slots, `pscore` and `dscore` also read 0 after reset.

Load acceptance:
- A load is accepted at a rising edge only when all of the following hold:
  - `resetb` is 1;
  - exactly one `load_*` strobe is 1;
  - `new_card` is in 1..13;
  - the target slot is currently 0 (empty).
- On acceptance, the target slot takes `new_card` and `cards_dealt` increments by 1.
- `cards_dealt` cannot exceed 6, because only six empty slots exist.

Load rejection:
- A load is rejected in any of these cases:
  - two or more strobes are high in the same cycle;
  - `new_card` is illegal (0, 14 or 15);
  - the target slot is already occupied.
- On rejection, no slot changes, `cards_dealt` is unchanged and `load_error` is set to 1.
- `load_error` stays at 1 until the next reset.
- A cycle with no strobe high changes nothing.

Card value:
- Ranks 1..9 are worth their face value.
- Ranks 10..13 and empty slots (0) are worth 0.

Scoring:
- Compute a 5-bit sum of the three slot values for each hand; the maximum is 27.
- Score = sum mod 10, computed by subtracting 20 if the sum is at least 20, otherwise subtracting 10 if it is at least 10.
- `pscore` and `dscore` are combinational from the registered slots; they contain no extra register.

`pcard3` output:
- This is the raw rank of the player's third card.
- It reads 0 until that card is loaded.

## Timing
- Load latency is one edge. A strobe sampled high at edge N makes the slot, `cards_dealt` and the affected score valid immediately after edge N.
- A strobe held high for several consecutive cycles behaves as follows:
  - the first edge loads the slot;
  - every later edge is a rejected reload, so `load_error` becomes 1.
- Strobes are therefore required to be one-cycle pulses.
- All registered outputs reset to 0, and all combinational outputs follow from them: `pcard1..3`, `dcard1..3`, `cards_dealt`, `load_error`, `pscore` and `dscore` all read 0.
- Reset asserted mid-hand clears the hand at that edge, even if a strobe is also high in the same cycle. The next hand starts from empty slots.
- There is no internal FSM; the hand sequence is dictated entirely by the strobes. Slots can be filled in any order.

## Test plan
- Reset: hold `resetb`=0 for 2 edges with `load_pcard1`=1 and `new_card`=5.
  - Required: all outputs are 0.
  - Required: `pcard1` stays 0 after `resetb` rises while no strobe is high.
- Normal hand, loading one card per edge with single-cycle strobes:
  - Load p1=9, d1=13, p2=5, d2=3.
  - Required: `pscore`=4, `dscore`=3, `cards_dealt`=4, `pcard3`=0.
  - Then load p3=2. Required: `pscore`=6, `pcard3`=2, `cards_dealt`=5.
- Wrap-around: load player cards 7, 8, 9.
  - Required: `pscore`=4 (sum 24).
  - Then load dealer cards 10, 11, 12. Required: `dscore`=0 and `cards_dealt`=6.
- Simultaneous strobes: assert `load_pcard1` and `load_dcard1` together with `new_card`=6.
  - Required: both slots remain 0, `cards_dealt`=0, `load_error`=1.
  - Required: `load_error` stays 1 after later legal loads, until reset.
- Illegal and duplicate loads:
  - Pulse `load_dcard2` with `new_card`=15. Required: `dcard2`=0 and `load_error`=1.
  - After reset, load p1=4, then pulse `load_pcard1` with `new_card`=8. Required: `pcard1` stays 4 and `load_error`=1.
- Reset mid-hand: after loading 3 cards, drop `resetb` for 1 edge.
  - Required: all slots 0, `cards_dealt`=0, `pscore`=`dscore`=0.
  - Required: a following p1=8 load gives `pscore`=8.
